// File: rtl/latch_m_wb_skid_pkg.sv
// Shared definitions for the MEM->WB latch: default widths, payload layout and skid occupancy states.
package latch_m_wb_skid_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    // Occupancy of a skid register: nothing, main entry only, or main plus skid entry.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Payload layout at the default widths, MSB first: {reg_write, mem_to_reg, alu_result, data_load, dst}.
    typedef struct packed {
        logic                  regWrite;
        logic                  memToReg;
        logic [DATA_W_DEF-1:0] aluResult;
        logic [DATA_W_DEF-1:0] dataLoad;
        logic [REG_AW_DEF-1:0] dst;
    } memWbPayload_t;

    function automatic int payloadWidth(input int dataW, input int regAw);
        return 2 + 2 * dataW + regAw;
    endfunction

endpackage

// File: rtl/latch_m_wb_skid_skid_reg.sv
// Generic valid/ready pipeline register with a one-entry skid buffer on an opaque W-bit payload.
// in_ready_o comes straight from a flop, so there is no combinational ready path upstream.
module skid_reg
    import latch_m_wb_skid_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    occ_e         state_q, state_d;
    logic [W-1:0] mData_q, mData_d;
    logic [W-1:0] sData_q, sData_d;
    logic         inReady_q, inReady_d;
    logic         accept, drain;

    assign out_valid_o = (state_q != OCC_EMPTY);
    assign out_data_o  = mData_q;
    assign in_ready_o  = inReady_q;
    assign accept      = in_valid_i & inReady_q;
    assign drain       = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        mData_d = mData_q;
        sData_d = sData_q;
        case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    state_d = OCC_ONE;
                    mData_d = in_data_i;
                end
            end
            OCC_ONE: begin
                if (accept && drain) begin
                    mData_d = in_data_i;
                end else if (accept) begin
                    state_d = OCC_TWO;
                    sData_d = in_data_i;
                end else if (drain) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // Ready is low here, so only a drain can move data: the skid entry slides into main.
                if (drain) begin
                    state_d = OCC_ONE;
                    mData_d = sData_q;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
        // Flush only clears the valid state; data flops are allowed to keep stale contents.
        if (flush_i) begin
            state_d = OCC_EMPTY;
        end
        inReady_d = (state_d != OCC_TWO);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= OCC_EMPTY;
            mData_q   <= '0;
            sData_q   <= '0;
            inReady_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            mData_q   <= mData_d;
            sData_q   <= sData_d;
            inReady_q <= inReady_d;
        end
    end

endmodule

// File: rtl/latch_m_wb_skid.sv
// MEM->WB pipeline latch: packs the MEM payload into a skid register and derives the write-back
// data, destination and write enable (with optional r0 suppression) purely from held state.
module latch_m_wb_skid
    import latch_m_wb_skid_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int REG_AW    = REG_AW_DEF,
    parameter bit ZERO_SUPP = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              reg_write_i,
    input  logic              mem_to_reg_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] data_load_i,
    input  logic [REG_AW-1:0] dst_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              wb_reg_write_o,
    output logic [REG_AW-1:0] wb_dst_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              fwd_valid_o
);

    localparam int PW = payloadWidth(DATA_W, REG_AW);

    logic [PW-1:0]     inPayload;
    logic [PW-1:0]     heldPayload;
    logic              heldRegWrite;
    logic              heldMemToReg;
    logic [DATA_W-1:0] heldAlu;
    logic [DATA_W-1:0] heldLoad;
    logic [REG_AW-1:0] heldDst;
    logic              suppress;

    assign inPayload = {reg_write_i, mem_to_reg_i, alu_result_i, data_load_i, dst_i};

    skid_reg #(
        .W(PW)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (inPayload),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (heldPayload)
    );

    assign {heldRegWrite, heldMemToReg, heldAlu, heldLoad, heldDst} = heldPayload;

    // r0 is hard-wired: the entry still flows but never writes the register file.
    assign suppress       = ZERO_SUPP && (heldDst == '0);
    assign wb_reg_write_o = out_valid_o & heldRegWrite & ~suppress;
    assign fwd_valid_o    = wb_reg_write_o;
    assign wb_dst_o       = heldDst;
    assign wb_data_o      = heldMemToReg ? heldLoad : heldAlu;

endmodule
